ex_mem_pipe_reg: RTL and testbench

//  EX/MEM pipeline register of the 5-stage RV64 core.

---
 rtl/ex_mem_pipe_reg_pkg.sv | 53 +++++
 rtl/ex_mem_pipe_reg_if.sv | 46 ++++
 rtl/ex_mem_pipe_reg_pipe_reg.sv | 22 ++
 rtl/ex_mem_pipe_reg.sv | 76 +++++++
 tb/tb_ex_mem_pipe_reg.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/ex_mem_pipe_reg_pkg.sv
// Shared EX/MEM pipeline types, widths and load/store funct3 encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ex_mem_pipe_reg_pkg;

  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

  // Load funct3 encodings
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;

  // Store funct3 encodings
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;
  localparam logic [2:0] SD  = 3'b011;

  // Control bits that a bubble must clear
  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_read;
    logic mem_write;
  } ctrl_t;

  // Payload carried alongside; content is irrelevant while the stage holds a bubble
  typedef struct packed {
    logic [XLEN-1:0]       alu_result;
    logic [XLEN-1:0]       rs2_data;
    logic [REG_ADDR_W-1:0] rd;
    logic                  mem_to_reg;
    logic [2:0]            funct3;
  } data_t;

  // True when funct3 is a legal size/sign code for the memory access being made
  function automatic logic ls_funct3_ok(input logic is_load, input logic is_store,
                                        input logic [2:0] f3);
    logic ok;
    ok = 1'b1;
    if (is_load)  ok = (f3 inside {LB, LH, LW, LD, LBU, LHU, LWU});
    if (is_store) ok = ok & (f3 inside {SB, SH, SW, SD});
    return ok;
  endfunction

endpackage

// File: rtl/ex_mem_pipe_reg_if.sv
// EX -> MEM stage boundary bundle: EX-side inputs, hazard controls, MEM-side outputs.
// Latency: n/a (wiring only).
// Backpressure: stall holds the MEM side; flush overrides stall.
interface ex_mem_pipe_reg_if;
  import ex_mem_pipe_reg_pkg::*;

  logic                  ex_valid;
  logic [XLEN-1:0]       ex_alu_result;
  logic [XLEN-1:0]       ex_rs2_data;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_reg_write;
  logic                  ex_mem_read;
  logic                  ex_mem_write;
  logic                  ex_mem_to_reg;
  logic [2:0]            ex_funct3;
  logic                  stall;
  logic                  flush;

  logic                  mem_valid;
  logic [XLEN-1:0]       mem_alu_result;
  logic [XLEN-1:0]       mem_rs2_data;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic                  mem_reg_write;
  logic                  mem_mem_read;
  logic                  mem_mem_write;
  logic                  mem_mem_to_reg;
  logic [2:0]            mem_funct3;
  logic                  fwd_mem_en;

  // EX stage / hazard unit side
  modport master (
    output ex_valid, ex_alu_result, ex_rs2_data, ex_rd, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_funct3, stall, flush,
    input  mem_valid, mem_alu_result, mem_rs2_data, mem_rd, mem_reg_write,
           mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_funct3, fwd_mem_en
  );

  // Pipeline register side
  modport slave (
    input  ex_valid, ex_alu_result, ex_rs2_data, ex_rd, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_funct3, stall, flush,
    output mem_valid, mem_alu_result, mem_rs2_data, mem_rd, mem_reg_write,
           mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_funct3, fwd_mem_en
  );

endinterface

// File: rtl/ex_mem_pipe_reg_pipe_reg.sv
// Generic W-bit register with load enable and synchronous clear.
// Latency: 1 cycle d -> q when en=1.
// Backpressure: en=0 holds q; clr wins over en and loads zero.
module pipe_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Clear beats load beats hold; async reset zeroes the bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register: qualified control + data, plus MEM-stage forward enable.
// Latency: 1 cycle EX inputs -> mem_* outputs; fwd_mem_en is comb from registered state.
// Backpressure: stall holds all outputs; flush inserts a bubble even while stalled.
module ex_mem_pipe_reg
  import ex_mem_pipe_reg_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  ex_mem_pipe_reg_if.slave bus
);

  ctrl_t ctrl_d, ctrl_q;
  data_t data_d, data_q;
  logic  en;
  logic  clr;

  // Only real instructions may act; x0 is never a write target
  always_comb begin
    ctrl_d           = '0;
    ctrl_d.valid     = bus.ex_valid;
    ctrl_d.reg_write = bus.ex_valid & bus.ex_reg_write & (bus.ex_rd != REG_X0);
    ctrl_d.mem_read  = bus.ex_valid & bus.ex_mem_read;
    ctrl_d.mem_write = bus.ex_valid & bus.ex_mem_write;
  end

  assign data_d = '{alu_result: bus.ex_alu_result,
                    rs2_data:   bus.ex_rs2_data,
                    rd:         bus.ex_rd,
                    mem_to_reg: bus.ex_mem_to_reg,
                    funct3:     bus.ex_funct3};

  // Flush must advance the register even when MEM is stalled
  assign en  = ~bus.stall | bus.flush;
  assign clr = bus.flush;

  pipe_reg #(.W($bits(ctrl_t))) u_ctrl_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .clr   (clr),
    .d     (ctrl_d),
    .q     (ctrl_q)
  );

  // Data fields are don't-care under a bubble, so no clear is needed
  pipe_reg #(.W($bits(data_t))) u_data_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .clr   (1'b0),
    .d     (data_d),
    .q     (data_q)
  );

  assign bus.mem_valid      = ctrl_q.valid;
  assign bus.mem_reg_write  = ctrl_q.reg_write;
  assign bus.mem_mem_read   = ctrl_q.mem_read;
  assign bus.mem_mem_write  = ctrl_q.mem_write;
  assign bus.mem_alu_result = data_q.alu_result;
  assign bus.mem_rs2_data   = data_q.rs2_data;
  assign bus.mem_rd         = data_q.rd;
  assign bus.mem_mem_to_reg = data_q.mem_to_reg;
  assign bus.mem_funct3     = data_q.funct3;

  // Forwarding only from registered state, so no path back into EX
  assign bus.fwd_mem_en = ctrl_q.valid & ctrl_q.reg_write & (data_q.rd != REG_X0);

  // Decode must never issue a simultaneous load and store
  a_no_ld_st: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.ex_valid && bus.ex_mem_read && bus.ex_mem_write));

  // Memory accesses must carry a legal size/sign code
  a_ls_funct3: assert property (@(posedge clk) disable iff (!rst_n)
    !bus.ex_valid || ls_funct3_ok(bus.ex_mem_read, bus.ex_mem_write, bus.ex_funct3));

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Scoreboard bench for ex_mem_pipe_reg: directed vectors, expected outputs queued per edge.
// Latency: expectations are popped #1 after each rising edge or reset assertion.
// Backpressure: stall/flush sequences are driven directly by the stimulus.
module tb_ex_mem_pipe_reg;

  logic clk;
  logic rst_n;

  ex_mem_pipe_reg_if bus ();

  ex_mem_pipe_reg dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic        valid;
    logic [63:0] alu;
    logic [63:0] rs2;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        m2r;
    logic [2:0]  f3;
    logic        fwd;
    logic        ctrl_only;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input string nm, input logic v, input logic [63:0] alu,
                              input logic [63:0] rs2, input logic [4:0] rd,
                              input logic rw, input logic mr, input logic mw,
                              input logic m2r, input logic [2:0] f3,
                              input logic fwd, input logic co);
    exp_t e;
    e.name = nm; e.valid = v; e.alu = alu; e.rs2 = rs2; e.rd = rd;
    e.rw = rw; e.mr = mr; e.mw = mw; e.m2r = m2r; e.f3 = f3;
    e.fwd = fwd; e.ctrl_only = co;
    return e;
  endfunction

  task automatic drive(input logic v, input logic [63:0] alu, input logic [63:0] rs2,
                       input logic [4:0] rd, input logic rw, input logic mr,
                       input logic mw, input logic m2r, input logic [2:0] f3,
                       input logic st, input logic fl);
    bus.ex_valid      = v;
    bus.ex_alu_result = alu;
    bus.ex_rs2_data   = rs2;
    bus.ex_rd         = rd;
    bus.ex_reg_write  = rw;
    bus.ex_mem_read   = mr;
    bus.ex_mem_write  = mw;
    bus.ex_mem_to_reg = m2r;
    bus.ex_funct3     = f3;
    bus.stall         = st;
    bus.flush         = fl;
  endtask

  // Monitor: compare DUT outputs with the oldest queued expectation
  initial begin
    exp_t e;
    logic ok;
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      if (sb_q.size() > 0) begin
        e  = sb_q.pop_front();
        ok = (bus.mem_valid == e.valid) && (bus.mem_reg_write == e.rw) &&
             (bus.mem_mem_read == e.mr) && (bus.mem_mem_write == e.mw) &&
             (bus.fwd_mem_en == e.fwd);
        if (!e.ctrl_only)
          ok = ok && (bus.mem_alu_result == e.alu) && (bus.mem_rs2_data == e.rs2) &&
               (bus.mem_rd == e.rd) && (bus.mem_mem_to_reg == e.m2r) &&
               (bus.mem_funct3 == e.f3);
        n_checks++;
        if (ok) n_pass++;
        else
          $display("FAIL %s: got v=%0b rw=%0b mr=%0b mw=%0b fwd=%0b alu=%h rs2=%h rd=%0d m2r=%0b f3=%0d | want v=%0b rw=%0b mr=%0b mw=%0b fwd=%0b alu=%h rs2=%h rd=%0d m2r=%0b f3=%0d",
                   e.name, bus.mem_valid, bus.mem_reg_write, bus.mem_mem_read,
                   bus.mem_mem_write, bus.fwd_mem_en, bus.mem_alu_result, bus.mem_rs2_data,
                   bus.mem_rd, bus.mem_mem_to_reg, bus.mem_funct3,
                   e.valid, e.rw, e.mr, e.mw, e.fwd, e.alu, e.rs2, e.rd, e.m2r, e.f3);
      end
    end
  end

  // Stimulus
  initial begin
    exp_t st_e;
    rst_n = 1'b0;
    drive(0, 64'h0, 64'h0, 5'd0, 0, 0, 0, 0, 3'd0, 0, 0);

    // Held in reset for two edges
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      sb_q.push_back(mk("reset", 0, 64'h0, 64'h0, 5'd0, 0, 0, 0, 0, 3'd0, 0, 0));
    end

    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 64'h0, 64'h0, 5'd0, 0, 0, 0, 0, 3'd0, 0, 0);
    sb_q.push_back(mk("post_reset_idle", 0, 64'h0, 64'h0, 5'd0, 0, 0, 0, 0, 3'd0, 0, 0));

    // sra result into rd=5
    @(negedge clk);
    drive(1, 64'hFFFF_FFFF_FFFF_FFF0, 64'h0, 5'd5, 1, 0, 0, 0, 3'd0, 0, 0);
    sb_q.push_back(mk("load_sra", 1, 64'hFFFF_FFFF_FFFF_FFF0, 64'h0, 5'd5, 1, 0, 0, 0, 3'd0, 1, 0));

    // write to x0 is suppressed
    @(negedge clk);
    drive(1, 64'h1234, 64'h0, 5'd0, 1, 0, 0, 0, 3'd0, 0, 0);
    sb_q.push_back(mk("x0_write", 1, 64'h1234, 64'h0, 5'd0, 0, 0, 0, 0, 3'd0, 0, 0));

    // store in a bubble does not write memory
    @(negedge clk);
    drive(0, 64'h2000, 64'h55, 5'd0, 0, 0, 1, 0, 3'd3, 0, 0);
    sb_q.push_back(mk("bubble_store", 0, 64'h2000, 64'h55, 5'd0, 0, 0, 0, 0, 3'd3, 0, 0));

    // real store (SW)
    @(negedge clk);
    drive(1, 64'h1000, 64'hDEAD_BEEF, 5'd0, 0, 0, 1, 0, 3'd2, 0, 0);
    st_e = mk("store", 1, 64'h1000, 64'hDEAD_BEEF, 5'd0, 0, 0, 1, 0, 3'd2, 0, 0);
    sb_q.push_back(st_e);

    // stall three cycles while EX changes underneath
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1, 64'hAAAA + 64'(i), 64'h1111 * 64'(i + 1), 5'(7 + i), 1, 0, 0, 1, 3'd1, 1, 0);
      st_e.name = $sformatf("stall_hold%0d", i);
      sb_q.push_back(st_e);
    end

    // stall drops: new instruction (LD into rd=9)
    @(negedge clk);
    drive(1, 64'h77, 64'h0, 5'd9, 1, 1, 0, 1, 3'd3, 0, 0);
    sb_q.push_back(mk("after_stall", 1, 64'h77, 64'h0, 5'd9, 1, 1, 0, 1, 3'd3, 1, 0));

    // flush and stall together: bubble wins
    @(negedge clk);
    drive(1, 64'h88, 64'h0, 5'd10, 1, 1, 0, 1, 3'd2, 1, 1);
    sb_q.push_back(mk("flush_over_stall", 0, 64'h0, 64'h0, 5'd0, 0, 0, 0, 0, 3'd0, 0, 1));

    // still stalled, no flush: bubble is held
    @(negedge clk);
    drive(1, 64'h88, 64'h0, 5'd10, 1, 1, 0, 1, 3'd2, 1, 0);
    sb_q.push_back(mk("bubble_hold", 0, 64'h0, 64'h0, 5'd0, 0, 0, 0, 0, 3'd0, 0, 1));

    // release: the held load enters MEM
    @(negedge clk);
    drive(1, 64'h88, 64'h0, 5'd10, 1, 1, 0, 1, 3'd2, 0, 0);
    sb_q.push_back(mk("reload_after_flush", 1, 64'h88, 64'h0, 5'd10, 1, 1, 0, 1, 3'd2, 1, 0));

    // back-to-back rd=1..4
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      drive(1, 64'h10 * 64'(i), 64'h0, 5'(i), 1, 0, 0, 0, 3'd0, 0, 0);
      sb_q.push_back(mk($sformatf("b2b_rd%0d", i), 1, 64'h10 * 64'(i), 64'h0, 5'(i),
                        1, 0, 0, 0, 3'd0, 1, 0));
    end

    // valid data in MEM, then async reset mid-cycle
    @(negedge clk);
    drive(1, 64'h30, 64'h0, 5'd3, 1, 0, 0, 0, 3'd0, 0, 0);
    sb_q.push_back(mk("pre_reset", 1, 64'h30, 64'h0, 5'd3, 1, 0, 0, 0, 3'd0, 1, 0));

    @(negedge clk);
    sb_q.push_back(mk("async_reset_immediate", 0, 64'h0, 64'h0, 5'd0, 0, 0, 0, 0, 3'd0, 0, 0));
    sb_q.push_back(mk("async_reset_edge", 0, 64'h0, 64'h0, 5'd0, 0, 0, 0, 0, 3'd0, 0, 0));
    rst_n = 1'b0;

    @(negedge clk);
    rst_n = 1'b1;
    sb_q.push_back(mk("post_reset_load", 1, 64'h30, 64'h0, 5'd3, 1, 0, 0, 0, 3'd0, 1, 0));

    @(negedge clk);
    drive(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 5'd31, 1, 0, 0, 0, 3'd0, 0, 0);
    sb_q.push_back(mk("rd31_ones", 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 5'd31, 1, 0, 0, 0, 3'd0, 1, 0));

    @(negedge clk);
    drive(0, 64'h0, 64'h0, 5'd0, 0, 0, 0, 0, 3'd0, 0, 0);

    // drain with a bounded wait
    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk);
    #2;
    if (sb_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
